mac_job_sequencer: RTL and testbench

Job-level controller that sits directly in front of `mac_cluster` and owns its operand, config and enable inputs. The sequencer accepts one dot-product job at a time: a mode and a beat count. It then streams that many operand beats into the cluster and clears the accumulators on the first beat. After the cluster pipeline drains, it presents the four accumulator words as a result with a valid/ready handshake. No upstream logic drives `mac_cluster` directly.

---
 rtl/mac_job_sequencer_pkg.sv | 28 ++
 rtl/mac_job_sequencer.sv | 162 ++++++++++++++++
 tb/tb_mac_job_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_job_sequencer_pkg.sv
// Shared constants for the MAC job sequencer: cluster operand/accumulator widths,
// mode encodings, sequencer state encodings and a mode-legality helper.
package mac_job_sequencer_pkg;

    localparam int MAC_MIN_WIDTH  = 8;
    localparam int MAC_ACC_WIDTH  = 16;
    localparam int MAC_CONF_WIDTH = 3;
    localparam int MAC_ACC_BIT    = MAC_CONF_WIDTH - 1;

    typedef logic [MAC_CONF_WIDTH-2:0] mac_mode_t;

    localparam mac_mode_t MAC_SINGLE = 2'd0;
    localparam mac_mode_t MAC_DUAL   = 2'd1;
    localparam mac_mode_t MAC_QUAD   = 2'd2;

    localparam logic [1:0] SEQ_IDLE  = 2'd0;
    localparam logic [1:0] SEQ_BUSY  = 2'd1;
    localparam logic [1:0] SEQ_DRAIN = 2'd2;
    localparam logic [1:0] SEQ_DONE  = 2'd3;

    function automatic logic mode_is_legal(input mac_mode_t mode);
        case (mode)
            MAC_SINGLE, MAC_DUAL, MAC_QUAD: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mac_job_sequencer.sv
// Job-level controller in front of mac_cluster: accepts one dot-product job,
// streams its operand beats (clearing on the first issue), waits for the
// cluster pipeline to drain and presents the accumulators as a result.
module mac_job_sequencer
    import mac_job_sequencer_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int MAC_LAT = 2
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      cmd_valid,
    output logic                                      cmd_ready,
    input  logic [MAC_CONF_WIDTH-2:0]                 cmd_mode,
    input  logic [LEN_W-1:0]                          cmd_len,
    input  logic                                      op_valid,
    output logic                                      op_ready,
    input  logic [4*MAC_MIN_WIDTH-1:0]                op_a,
    input  logic [4*MAC_MIN_WIDTH-1:0]                op_b,
    output logic                                      res_valid,
    input  logic                                      res_ready,
    output logic [4*MAC_ACC_WIDTH-1:0]                res_data,
    output logic                                      res_err,
    output logic                                      mac_rst,
    output logic                                      mac_en,
    output logic [4*MAC_MIN_WIDTH-1:0]                mac_a,
    output logic [4*MAC_MIN_WIDTH-1:0]                mac_b,
    output logic [4*MAC_ACC_WIDTH+MAC_CONF_WIDTH-1:0] mac_cfg,
    input  logic [4*MAC_ACC_WIDTH-1:0]                mac_out
);

    localparam int              DRN_W    = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(MAC_LAT - 1);

    logic [1:0]                 state_q, state_d;
    mac_mode_t                  mode_q, mode_d;
    logic [LEN_W-1:0]           rem_q, rem_d;
    logic                       first_q, first_d;
    logic                       err_q, err_d;
    logic [DRN_W-1:0]           drn_q, drn_d;
    logic                       acc_q, acc_d;
    logic [4*MAC_MIN_WIDTH-1:0] a_q, a_d;
    logic [4*MAC_MIN_WIDTH-1:0] b_q, b_d;
    logic                       op_ready_s;
    logic                       beat_s;

    assign op_ready_s = (state_q == SEQ_BUSY) && (rem_q != {LEN_W{1'b0}});
    assign beat_s     = op_ready_s && op_valid;

    // Next-state and next-issue logic; anything not explicitly issued is a hold issue.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        first_d = first_q;
        err_d   = err_q;
        drn_d   = drn_q;
        acc_d   = 1'b1;
        a_d     = {(4*MAC_MIN_WIDTH){1'b0}};
        b_d     = {(4*MAC_MIN_WIDTH){1'b0}};
        case (state_q)
            SEQ_IDLE: begin
                if (cmd_valid) begin
                    rem_d   = cmd_len;
                    first_d = 1'b1;
                    if (mode_is_legal(cmd_mode)) begin
                        mode_d  = cmd_mode;
                        err_d   = 1'b0;
                        state_d = SEQ_BUSY;
                    end else begin
                        err_d   = 1'b1;
                        state_d = SEQ_DONE;
                    end
                end else begin
                    state_d = SEQ_IDLE;
                end
            end
            SEQ_BUSY: begin
                // The first issue of a job clears, even when it carries no beat.
                acc_d   = ~first_q;
                first_d = 1'b0;
                if (beat_s) begin
                    a_d   = op_a;
                    b_d   = op_b;
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = SEQ_DRAIN;
                        drn_d   = DRN_LOAD;
                    end else begin
                        state_d = SEQ_BUSY;
                    end
                end else if (rem_q == {LEN_W{1'b0}}) begin
                    state_d = SEQ_DRAIN;
                    drn_d   = DRN_LOAD;
                end else begin
                    state_d = SEQ_BUSY;
                end
            end
            SEQ_DRAIN: begin
                if (drn_q == {DRN_W{1'b0}}) begin
                    state_d = SEQ_DONE;
                end else begin
                    drn_d = drn_q - DRN_W'(1);
                end
            end
            SEQ_DONE: begin
                if (res_ready) begin
                    state_d = SEQ_IDLE;
                    err_d   = 1'b0;
                end else begin
                    state_d = SEQ_DONE;
                end
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    // State, counters and the registered cluster issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEQ_IDLE;
            mode_q  <= MAC_SINGLE;
            rem_q   <= {LEN_W{1'b0}};
            first_q <= 1'b0;
            err_q   <= 1'b0;
            drn_q   <= {DRN_W{1'b0}};
            acc_q   <= 1'b0;
            a_q     <= {(4*MAC_MIN_WIDTH){1'b0}};
            b_q     <= {(4*MAC_MIN_WIDTH){1'b0}};
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            first_q <= first_d;
            err_q   <= err_d;
            drn_q   <= drn_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Config word: initial-value fields stay zero, accumulate bit above the mode.
    always_comb begin
        mac_cfg                       = {(4*MAC_ACC_WIDTH+MAC_CONF_WIDTH){1'b0}};
        mac_cfg[MAC_CONF_WIDTH-2:0]   = mode_q;
        mac_cfg[MAC_ACC_BIT]          = acc_q;
    end

    assign cmd_ready = (state_q == SEQ_IDLE);
    assign op_ready  = op_ready_s;
    assign res_valid = (state_q == SEQ_DONE);
    assign res_data  = mac_out;
    assign res_err   = err_q;
    assign mac_rst   = rst;
    assign mac_en    = 1'b1;
    assign mac_a     = a_q;
    assign mac_b     = b_q;

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Directed bench for mac_job_sequencer with a behavioural two-stage mac_cluster
// model closing the loop from mac_a/mac_b/mac_cfg back to mac_out.
module tb_mac_job_sequencer;
    import mac_job_sequencer_pkg::*;

    localparam int LEN_W   = 16;
    localparam int MAC_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_mode = 2'd0;
    logic [15:0] cmd_len = 16'd0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [63:0] res_data;
    logic        res_err;
    logic        mac_rst;
    logic        mac_en;
    logic [31:0] mac_a;
    logic [31:0] mac_b;
    logic [66:0] mac_cfg;
    logic [63:0] mac_out;

    int checks = 0;
    int errors = 0;

    mac_job_sequencer #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_len(cmd_len),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .mac_rst(mac_rst), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
        .mac_cfg(mac_cfg), .mac_out(mac_out)
    );

    always #5 clk = ~clk;

    // Cluster model: accumulate one edge after the issue, output one edge later.
    function automatic logic [63:0] cl_next(input logic [63:0] acc, input logic [31:0] a,
                                            input logic [31:0] b, input logic [2:0] cfg);
        logic [63:0] r;
        logic [15:0] p16;
        logic [31:0] p32;
        logic [63:0] p64;
        r = acc;
        case (cfg[1:0])
            2'd0: for (int i = 0; i < 4; i++) begin
                p16 = {8'd0, a[8*i+:8]} * {8'd0, b[8*i+:8]};
                r[16*i+:16] = cfg[2] ? acc[16*i+:16] + p16 : p16;
            end
            2'd1: for (int j = 0; j < 2; j++) begin
                p32 = {16'd0, a[16*j+:16]} * {16'd0, b[16*j+:16]};
                r[32*j+:32] = cfg[2] ? acc[32*j+:32] + p32 : p32;
            end
            2'd2: begin
                p64 = {32'd0, a} * {32'd0, b};
                r = cfg[2] ? acc + p64 : p64;
            end
            default: r = acc;
        endcase
        return r;
    endfunction

    logic [63:0] acc_m;
    always @(posedge clk) begin
        if (mac_rst) begin
            acc_m   <= 64'd0;
            mac_out <= 64'd0;
        end else if (mac_en) begin
            acc_m   <= cl_next(acc_m, mac_a, mac_b, mac_cfg[2:0]);
            mac_out <= acc_m;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_cmd(input logic [1:0] m, input logic [15:0] l);
        cmd_valid = 1'b1; cmd_mode = m; cmd_len = l;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic beat(input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1; op_a = a; op_b = b;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic wait_res(output int n);
        n = 0;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic accept_res();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%0h exp=1", cmd_ready); end
        checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL reset_op_ready got=%0h exp=0", op_ready); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%0h exp=0", res_valid); end
        checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL reset_res_err got=%0h exp=0", res_err); end
        checks++; if ({mac_a, mac_b} !== 64'd0) begin errors++; $display("FAIL reset_mac_ab got=%0h exp=0", {mac_a, mac_b}); end
        checks++; if (mac_cfg !== 67'd0) begin errors++; $display("FAIL reset_mac_cfg got=%0h exp=0", mac_cfg); end
        checks++; if (mac_rst !== 1'b1) begin errors++; $display("FAIL reset_mac_rst got=%0h exp=1", mac_rst); end
        checks++; if (mac_en !== 1'b1) begin errors++; $display("FAIL reset_mac_en got=%0h exp=1", mac_en); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (mac_rst !== 1'b0) begin errors++; $display("FAIL release_mac_rst got=%0h exp=0", mac_rst); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL release_cmd_ready got=%0h exp=1", cmd_ready); end
    endtask

    task automatic test_single_three();
        int n;
        start_cmd(MAC_SINGLE, 16'd3);
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL single_op_ready got=%0h exp=1", op_ready); end
        beat(32'h0202_0202, 32'h0303_0303);
        checks++; if (mac_a !== 32'h0202_0202) begin errors++; $display("FAIL single_mac_a got=%0h exp=02020202", mac_a); end
        checks++; if (mac_cfg[2:0] !== 3'b000) begin errors++; $display("FAIL single_first_clear got=%0h exp=0", mac_cfg[2:0]); end
        beat(32'h0202_0202, 32'h0303_0303);
        beat(32'h0202_0202, 32'h0303_0303);
        checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL single_drain_op_ready got=%0h exp=0", op_ready); end
        wait_res(n);
        checks++; if (n + 4 !== 6) begin errors++; $display("FAIL single_latency got=%0d exp=6", n + 4); end
        checks++; if (res_data !== 64'h0012_0012_0012_0012) begin errors++; $display("FAIL single_data got=%0h exp=0012001200120012", res_data); end
        checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL single_err got=%0h exp=0", res_err); end
        accept_res();
        checks++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL single_release got=%0h%0h exp=01", res_valid, cmd_ready); end
    endtask

    task automatic test_dual_bubble();
        int n;
        start_cmd(MAC_DUAL, 16'd2);
        beat(32'h0001_0005, 32'h0001_0007);
        checks++; if (mac_cfg[2:0] !== 3'b001) begin errors++; $display("FAIL dual_first_cfg got=%0h exp=1", mac_cfg[2:0]); end
        @(negedge clk);
        checks++; if (mac_cfg[2:0] !== 3'b101) begin errors++; $display("FAIL dual_bubble_cfg got=%0h exp=5", mac_cfg[2:0]); end
        checks++; if (op_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL dual_bubble_hs got=%0h%0h exp=10", op_ready, res_valid); end
        beat(32'h0001_0005, 32'h0001_0007);
        wait_res(n);
        checks++; if (res_data !== 64'h0000_0002_0000_0046) begin errors++; $display("FAIL dual_data got=%0h exp=0000000200000046", res_data); end
        accept_res();
    endtask

    task automatic test_back_to_back();
        int n;
        start_cmd(MAC_QUAD, 16'd1);
        beat(32'd3, 32'd3);
        wait_res(n);
        // a command offered while the result is held must be ignored
        cmd_valid = 1'b1; cmd_mode = MAC_DUAL; cmd_len = 16'd7;
        for (int k = 0; k < 5; k++) begin
            checks++; if (res_valid !== 1'b1 || res_data !== 64'd9) begin errors++; $display("FAIL b2b_hold%0d got=%0h/%0h exp=1/9", k, res_valid, res_data); end
            @(negedge clk);
        end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_cmd_ready_done got=%0h exp=0", cmd_ready); end
        cmd_valid = 1'b0;
        accept_res();
        checks++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap got=%0h%0h exp=10", cmd_ready, res_valid); end
        checks++; if (mac_cfg[1:0] !== MAC_QUAD) begin errors++; $display("FAIL b2b_mode_kept got=%0h exp=2", mac_cfg[1:0]); end
        start_cmd(MAC_QUAD, 16'd1);
        beat(32'd4, 32'd4);
        wait_res(n);
        checks++; if (res_data !== 64'd16) begin errors++; $display("FAIL b2b_second got=%0h exp=10", res_data); end
        accept_res();
    endtask

    task automatic test_zero_length();
        int n;
        logic seen;
        seen = 1'b0;
        op_valid = 1'b1; op_a = 32'h0505_0505; op_b = 32'h0505_0505;
        start_cmd(MAC_SINGLE, 16'd0);
        n = 1;
        while (!res_valid && n < 100) begin
            if (op_ready) seen = 1'b1;
            @(negedge clk);
            n++;
        end
        op_valid = 1'b0;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL zero_op_ready got=%0h exp=0", seen); end
        // clear issue takes one edge, then MAC_LAT edges of drain
        checks++; if (n !== 4) begin errors++; $display("FAIL zero_latency got=%0d exp=4", n); end
        checks++; if (res_data !== 64'd0) begin errors++; $display("FAIL zero_data got=%0h exp=0", res_data); end
        accept_res();
    endtask

    task automatic test_illegal_mode();
        op_valid = 1'b1; op_a = 32'h1111_1111; op_b = 32'h1111_1111;
        start_cmd(2'd3, 16'd4);
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL illegal_done got=%0h exp=1", res_valid); end
        checks++; if (res_err !== 1'b1) begin errors++; $display("FAIL illegal_err got=%0h exp=1", res_err); end
        checks++; if (mac_cfg[1:0] !== MAC_SINGLE) begin errors++; $display("FAIL illegal_mode_kept got=%0h exp=0", mac_cfg[1:0]); end
        repeat (2) @(negedge clk);
        checks++; if (op_ready !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL illegal_ready got=%0h%0h exp=00", op_ready, cmd_ready); end
        op_valid = 1'b0;
        accept_res();
    endtask

    task automatic test_reset_mid_job();
        int n;
        start_cmd(MAC_SINGLE, 16'd5);
        beat(32'h0909_0909, 32'h0909_0909);
        beat(32'h0909_0909, 32'h0909_0909);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (cmd_ready !== 1'b1 || op_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%0h%0h exp=10", cmd_ready, op_ready); end
        checks++; if (res_valid !== 1'b0 || res_err !== 1'b0) begin errors++; $display("FAIL midrst_res got=%0h%0h exp=00", res_valid, res_err); end
        checks++; if ({mac_a, mac_b} !== 64'd0 || mac_cfg !== 67'd0) begin errors++; $display("FAIL midrst_issue got=%0h/%0h exp=0/0", {mac_a, mac_b}, mac_cfg); end
        start_cmd(MAC_SINGLE, 16'd1);
        beat(32'h0101_0101, 32'h0101_0101);
        wait_res(n);
        checks++; if (n + 2 !== 4) begin errors++; $display("FAIL midrst_latency got=%0d exp=4", n + 2); end
        checks++; if (res_data !== 64'h0001_0001_0001_0001) begin errors++; $display("FAIL midrst_data got=%0h exp=0001000100010001", res_data); end
        accept_res();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_three();
        test_dual_bubble();
        test_back_to_back();
        test_zero_length();
        test_illegal_mode();
        test_reset_mid_job();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
